// File: rtl/ccr_unit_if.sv
// ccr_unit_if: bundles the execute-stage control/flag inputs and the
// condition-code outputs of ccr_unit.
//   master : the driving side (pipeline control, ALU); drives the inputs and observes the flags.
//   slave  : ccr_unit itself.
// Signals:
//   stall, flush          pipeline control
//   alu_op, alu_carry, alu_zero, alu_neg   ALU control and raw flag outputs
//   jmp_type              jump type of the instruction in execute
//   int_save, rti         interrupt entry / return (push / pop the flags)
//   flags                 {C,N,Z}; flags_word is flags zero-extended to N bits
//   take_branch           combinational jump decision
//   save_depth, save_err  save-stack occupancy and sticky error
interface ccr_unit_if #(
  parameter int unsigned N = 16
);
  logic         stall;
  logic         flush;
  logic [3:0]   alu_op;
  logic         alu_carry;
  logic         alu_zero;
  logic         alu_neg;
  logic [2:0]   jmp_type;
  logic         int_save;
  logic         rti;
  logic [2:0]   flags;
  logic [N-1:0] flags_word;
  logic         take_branch;
  logic [1:0]   save_depth;
  logic         save_err;

  modport master (
    output stall, flush, alu_op, alu_carry, alu_zero, alu_neg,
           jmp_type, int_save, rti,
    input  flags, flags_word, take_branch, save_depth, save_err
  );

  modport slave (
    input  stall, flush, alu_op, alu_carry, alu_zero, alu_neg,
           jmp_type, int_save, rti,
    output flags, flags_word, take_branch, save_depth, save_err
  );
endinterface

// File: rtl/ccr_unit.sv
// ccr_unit: condition-code register stage after the execute-stage ALU.
// Latches the ALU zero/negative/carry flags by alu_op. It resolves conditional
// jumps against the held flags, and a taken conditional jump clears the tested flag.
// It saves and restores the flags across interrupt entry and RTI on a small LIFO.
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   bus         ccr_unit_if.slave (see interface header for the signal list)
// Configuration:
//   CCR_NESTED_INT_EN  defined -> two-slot save stack (save_depth 0..2);
//                      undefined -> one slot, save_depth[1] tied to 0.
module ccr_unit #(
  parameter int unsigned N = 16
) (
  input  logic       clk,
  input  logic       rst,
  ccr_unit_if.slave  bus
);

  // Bit positions inside {C,N,Z}
  localparam int unsigned ZB = 0;
  localparam int unsigned NB = 1;
  localparam int unsigned CB = 2;

  localparam logic [2:0] JT_JZ  = 3'd1;
  localparam logic [2:0] JT_JN  = 3'd2;
  localparam logic [2:0] JT_JC  = 3'd3;
  localparam logic [2:0] JT_JMP = 3'd4;

  logic [2:0] flags_q, flags_d;
  logic       err_q, err_d;
  logic [2:0] slot0_q, slot0_d;
`ifdef CCR_NESTED_INT_EN
  logic [1:0] depth_q, depth_d;
  logic [2:0] slot1_q, slot1_d;
`else
  logic       depth_q, depth_d;
`endif

  logic [2:0] alu_flags;
  logic [2:0] clr_mask;
  logic [2:0] post_flags;
  logic [2:0] top_entry;
  logic       stk_full;
  logic       stk_empty;
  logic       take;

  // Flags as the ALU op alone would leave them
  always_comb begin
    alu_flags = flags_q;
    case (bus.alu_op)
      4'd1, 4'd7, 4'd8: begin
        alu_flags[ZB] = bus.alu_zero;
        alu_flags[NB] = bus.alu_neg;
      end
      4'd2, 4'd3, 4'd5, 4'd6: begin
        alu_flags[ZB] = bus.alu_zero;
        alu_flags[NB] = bus.alu_neg;
        alu_flags[CB] = bus.alu_carry;
      end
      4'd11:   alu_flags[CB] = 1'b1;
      4'd12:   alu_flags[CB] = 1'b0;
      default: ;
    endcase
  end

  // A taken conditional jump clears its tested bit. The bit is set exactly
  // when the jump is taken, so the mask is the held bit itself.
  always_comb begin
    clr_mask = 3'b000;
    case (bus.jmp_type)
      JT_JZ:   clr_mask[ZB] = flags_q[ZB];
      JT_JN:   clr_mask[NB] = flags_q[NB];
      JT_JC:   clr_mask[CB] = flags_q[CB];
      default: ;
    endcase
  end

  // The clear wins over the ALU update on the same bit
  assign post_flags = alu_flags & ~clr_mask;

  // Jump decision from registered flags only; stall does not mask it
  always_comb begin
    take = 1'b0;
    if (!bus.flush) begin
      case (bus.jmp_type)
        JT_JZ:   take = flags_q[ZB];
        JT_JN:   take = flags_q[NB];
        JT_JC:   take = flags_q[CB];
        JT_JMP:  take = 1'b1;
        default: take = 1'b0;
      endcase
    end
  end

  // Save-stack occupancy and top-of-stack view
`ifdef CCR_NESTED_INT_EN
  assign stk_full  = (depth_q == 2'd2);
  assign stk_empty = (depth_q == 2'd0);
  assign top_entry = (depth_q == 2'd2) ? slot1_q : slot0_q;
`else
  assign stk_full  = depth_q;
  assign stk_empty = ~depth_q;
  assign top_entry = slot0_q;
`endif

  // Next-state: rti > jump clear > ALU update > int_save capture
  always_comb begin
    flags_d = flags_q;
    err_d   = err_q;
    depth_d = depth_q;
    slot0_d = slot0_q;
`ifdef CCR_NESTED_INT_EN
    slot1_d = slot1_q;
`endif
    if (!bus.stall && !bus.flush) begin
      if (bus.rti) begin
        // A push coinciding with a pop is always dropped
        if (bus.int_save) begin
          err_d = 1'b1;
        end
        if (stk_empty) begin
          flags_d = post_flags;
          err_d   = 1'b1;
        end else begin
          flags_d = top_entry;
`ifdef CCR_NESTED_INT_EN
          depth_d = depth_q - 2'd1;
`else
          depth_d = 1'b0;
`endif
        end
      end else begin
        flags_d = post_flags;
        if (bus.int_save) begin
          if (stk_full) begin
            err_d = 1'b1;
          end else begin
`ifdef CCR_NESTED_INT_EN
            if (depth_q == 2'd0) begin
              slot0_d = post_flags;
            end else begin
              slot1_d = post_flags;
            end
            depth_d = depth_q + 2'd1;
`else
            slot0_d = post_flags;
            depth_d = 1'b1;
`endif
          end
        end
      end
    end
  end

  // State registers; stall freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 3'b000;
      err_q   <= 1'b0;
      slot0_q <= 3'b000;
`ifdef CCR_NESTED_INT_EN
      depth_q <= 2'd0;
      slot1_q <= 3'b000;
`else
      depth_q <= 1'b0;
`endif
    end else begin
      flags_q <= flags_d;
      err_q   <= err_d;
      slot0_q <= slot0_d;
      depth_q <= depth_d;
`ifdef CCR_NESTED_INT_EN
      slot1_q <= slot1_d;
`endif
    end
  end

  assign bus.flags       = flags_q;
  assign bus.flags_word  = N'(flags_q);
  assign bus.take_branch = take;
  assign bus.save_err    = err_q;
`ifdef CCR_NESTED_INT_EN
  assign bus.save_depth  = depth_q;
`else
  assign bus.save_depth  = {1'b0, depth_q};
`endif

endmodule

// File: tb/tb_ccr_unit.sv
// tb_ccr_unit: bench for ccr_unit. The driver applies one stimulus per cycle
// and pushes the expected outputs for that cycle into a queue. The monitor
// pops that entry on the falling edge and compares it. Expected values come from a
// flag/stack model built on plain bits and a queue, plus fixed values for
// the hand-written scenarios.
module tb_ccr_unit;

  localparam int unsigned N = 16;
`ifdef CCR_NESTED_INT_EN
  localparam int MAXD = 2;
`else
  localparam int MAXD = 1;
`endif

  typedef struct {
    bit       rst;
    bit       stall;
    bit       flush;
    bit [3:0] op;
    bit       c;
    bit       z;
    bit       n;
    bit [2:0] jt;
    bit       sv;
    bit       rti;
  } stim_t;

  typedef struct {
    bit [2:0] flags;
    bit       tb;
    bit [1:0] depth;
    bit       err;
  } exp_t;

  logic clk;
  logic rst;
  ccr_unit_if #(.N(N)) bus ();

  ccr_unit #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  // Reference state: individual flags and a LIFO of saved {C,N,Z}
  bit       mz, mn, mc, merr;
  bit [2:0] mstk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit model_tb(input stim_t s);
    if (s.flush) return 1'b0;
    case (s.jt)
      3'd1:    return mz;
      3'd2:    return mn;
      3'd3:    return mc;
      3'd4:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance the model by one clock edge
  task automatic model_step(input stim_t s);
    bit nz, nn, nc;
    bit [2:0] e;
    if (s.rst) begin
      mz = 0; mn = 0; mc = 0; merr = 0;
      mstk.delete();
    end else if (!s.stall && !s.flush) begin
      nz = mz; nn = mn; nc = mc;
      if (s.op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8}) begin
        nz = s.z; nn = s.n;
      end
      if (s.op inside {4'd2, 4'd3, 4'd5, 4'd6}) nc = s.c;
      if (s.op == 4'd11) nc = 1'b1;
      if (s.op == 4'd12) nc = 1'b0;
      if (s.jt == 3'd1 && mz) nz = 1'b0;
      if (s.jt == 3'd2 && mn) nn = 1'b0;
      if (s.jt == 3'd3 && mc) nc = 1'b0;
      if (s.rti) begin
        if (s.sv) merr = 1'b1;
        if (mstk.size() > 0) begin
          e = mstk.pop_back();
          {mc, mn, mz} = e;
        end else begin
          merr = 1'b1;
          mz = nz; mn = nn; mc = nc;
        end
      end else begin
        mz = nz; mn = nn; mc = nc;
        if (s.sv) begin
          if (mstk.size() < MAXD) mstk.push_back({nc, nn, nz});
          else merr = 1'b1;
        end
      end
    end
  endtask

  // One cycle: apply inputs, sample take_branch, queue expectation, clock
  task automatic drive(input stim_t s, output bit tb_act);
    exp_t e;
    rst          = s.rst;
    bus.stall    = s.stall;
    bus.flush    = s.flush;
    bus.alu_op   = s.op;
    bus.alu_carry= s.c;
    bus.alu_zero = s.z;
    bus.alu_neg  = s.n;
    bus.jmp_type = s.jt;
    bus.int_save = s.sv;
    bus.rti      = s.rti;
    #1;
    tb_act  = bus.take_branch;
    e.flags = {mc, mn, mz};
    e.tb    = model_tb(s);
    e.depth = 2'(mstk.size());
    e.err   = merr;
    sb_q.push_back(e);
    model_step(s);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input bit [2:0] f, input bit [1:0] d, input bit er);
    check({tag, "_flags"}, 32'(bus.flags), 32'(f));
    check({tag, "_depth"}, 32'(bus.save_depth), 32'(d));
    check({tag, "_err"},   32'(bus.save_err), 32'(er));
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_flags", 32'(bus.flags), 32'(e.flags));
        check("sb_word",  32'(bus.flags_word), 32'(e.flags));
        check("sb_take",  32'(bus.take_branch), 32'(e.tb));
        check("sb_depth", 32'(bus.save_depth), 32'(e.depth));
        check("sb_err",   32'(bus.save_err), 32'(e.err));
      end
    end
  end

  initial begin
    stim_t s;
    bit    t;
    int    wait_cnt;

    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.alu_op = 0; bus.alu_carry = 0;
    bus.alu_zero = 0; bus.alu_neg = 0; bus.jmp_type = 0;
    bus.int_save = 0; bus.rti = 0;
    mz = 0; mn = 0; mc = 0; merr = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset and idle
    drive(idle(), t);
    check("idle_take", 32'(t), 32'd0);
    chk_state("reset", 3'b000, 2'd0, 1'b0);
    check("reset_word", 32'(bus.flags_word), 32'd0);

    // SUB with zero and carry
    s = idle(); s.op = 4'd6; s.z = 1; s.c = 1;
    drive(s, t);
    check("sub_flags", 32'(bus.flags), 32'b101);

    // AND keeps C
    s = idle(); s.op = 4'd7; s.z = 0; s.n = 1;
    drive(s, t);
    check("and_flags", 32'(bus.flags), 32'b110);

    // NOT to set Z, then JZ taken clears Z
    s = idle(); s.op = 4'd1; s.z = 1;
    drive(s, t);
    check("not_flags", 32'(bus.flags), 32'b101);
    s = idle(); s.jt = 3'd1;
    drive(s, t);
    check("jz_take", 32'(t), 32'd1);
    check("jz_clear", 32'(bus.flags), 32'b100);

    // Flushed JZ: not taken, Z kept
    s = idle(); s.op = 4'd1; s.z = 1;
    drive(s, t);
    s = idle(); s.jt = 3'd1; s.flush = 1;
    drive(s, t);
    check("jz_flush_take", 32'(t), 32'd0);
    check("jz_flush_flags", 32'(bus.flags), 32'b101);

    // Build 011, save, SETC, RTI
    s = idle(); s.op = 4'd12;
    drive(s, t);
    s = idle(); s.op = 4'd1; s.z = 1; s.n = 1;
    drive(s, t);
    check("pre_save", 32'(bus.flags), 32'b011);
    s = idle(); s.sv = 1;
    drive(s, t);
    chk_state("save", 3'b011, 2'd1, 1'b0);
    s = idle(); s.op = 4'd11;
    drive(s, t);
    chk_state("setc", 3'b111, 2'd1, 1'b0);
    s = idle(); s.rti = 1;
    drive(s, t);
    chk_state("rti", 3'b011, 2'd0, 1'b0);

    // Two pushes, then pops
    s = idle(); s.sv = 1;
    drive(s, t);
    s = idle(); s.sv = 1; s.op = 4'd1;
    drive(s, t);
`ifdef CCR_NESTED_INT_EN
    chk_state("push2", 3'b000, 2'd2, 1'b0);
    s = idle(); s.rti = 1;
    drive(s, t);
    chk_state("pop2", 3'b000, 2'd1, 1'b0);
    drive(s, t);
    chk_state("pop1", 3'b011, 2'd0, 1'b0);
`else
    chk_state("push2", 3'b000, 2'd1, 1'b1);
    s = idle(); s.rti = 1;
    drive(s, t);
    chk_state("pop1", 3'b011, 2'd0, 1'b1);
`endif
    // Pop when empty
    s = idle(); s.rti = 1;
    drive(s, t);
    chk_state("pop_empty", 3'b011, 2'd0, 1'b1);

    // Stall freezes CLRC
    s = idle(); s.op = 4'd11;
    drive(s, t);
    s = idle(); s.op = 4'd12; s.stall = 1;
    repeat (3) begin
      drive(s, t);
      check("stall_flags", 32'(bus.flags), 32'b111);
    end

    // Reset mid-interrupt
    s = idle(); s.sv = 1;
    drive(s, t);
    check("pre_rst_depth", 32'(bus.save_depth), 32'd1);
    s = idle(); s.rst = 1;
    drive(s, t);
    chk_state("mid_rst", 3'b000, 2'd0, 1'b0);
    check("mid_rst_word", 32'(bus.flags_word), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      s.rst   = ($urandom_range(63) == 0);
      s.stall = ($urandom_range(7) == 0);
      s.flush = ($urandom_range(7) == 0);
      s.op    = 4'($urandom_range(15));
      s.c     = 1'($urandom_range(1));
      s.z     = 1'($urandom_range(1));
      s.n     = 1'($urandom_range(1));
      s.jt    = 3'($urandom_range(7));
      s.sv    = ($urandom_range(4) == 0);
      s.rti   = ($urandom_range(4) == 0);
      drive(s, t);
    end

    drive(idle(), t);
    wait_cnt = 0;
    while (sb_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccr_unit.md
# ccr_unit

Condition-code register stage directly downstream of the execute-stage ALU. It latches the ALU's zero, negative and carry outputs according to the ALU control signal and resolves conditional jumps against the held flags. Taken jumps clear the tested flag. It also saves and restores the flags across interrupt entry and RTI. The fetch/branch logic consumes its outputs, and the status-save path uses them on interrupts.

## Interface
- `N`, default 16: ALU data width; sets the width of `flags_word`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: holds all state this cycle.
- `flush` in 1: squashes this cycle's flag effects.
- `alu_op` in 4: ALU control signal for the instruction in execute.
- `alu_carry` in 1: ALU carry output.
- `alu_zero` in 1: ALU zero output.
- `alu_neg` in 1: ALU negative output.
- `jmp_type` in 3: jump type; 0 none, 1 JZ, 2 JN, 3 JC, 4 JMP; 5–7 are treated as none.
- `int_save` in 1: interrupt entry; pushes the flags.
- `rti` in 1: return from interrupt; pops the flags.
- `flags` out 3: {C,N,Z}, registered.
- `flags_word` out N: `flags` zero-extended to N bits, for the stack write path.
- `take_branch` out 1: combinational jump decision.
- `save_depth` out 2: number of occupied save slots.
- `save_err` out 1: sticky push-when-full or pop-when-empty error.

## Operation
- Flag update by `alu_op`, applied when neither `stall` nor `flush` is asserted:
  - 1 (NOT): Z and N updated; C held.
  - 2, 3, 5, 6 (INC, DEC, ADD, SUB): Z, N and C updated.
  - 7, 8 (AND, OR): Z and N updated; C held.
  - 11 (SETC): C=1; Z and N held.
  - 12 (CLRC): C=0; Z and N held.
  - 0, 4, 9, 10, 13, 14, 15: no flag change.
- `take_branch` is computed from the registered flags only:
  - JZ: `flags`.Z; JN: `flags`.N; JC: `flags`.C.
  - JMP: 1.
  - none, 5–7, or `flush`=1: 0.
  - `stall` does not mask `take_branch`.
- Taken conditional jump: the tested flag is cleared on the next edge. JMP clears nothing.
- If a flag update and a jump clear hit the same bit in the same cycle, the clear wins.
- Save stack:
  - Depth 1, or 2 when the configuration macro is defined. LIFO.
  - `int_save` pushes the post-update flags, i.e. the value `flags` would take this edge.
  - `rti` loads `flags` from the top entry and pops it. It overrides any ALU update or jump clear in that cycle.
- Simultaneous `int_save` and `rti`: the RTI pop executes; the push is dropped and `save_err` is set.
- Push when full: the push is dropped, the stack is unchanged, `save_err` is set, and the flag update still applies.
- Pop when empty: `flags` and the ALU update proceed as if `rti`=0, and `save_err` is set.
- `save_err` clears only on `rst`.
- Precedence per edge: `rst` > `stall` > `flush` > `rti` > jump clear > ALU update > `int_save` capture.
- `flush` suppresses the ALU update, jump clear, push and pop.

## Timing
- Reset values: `flags`=3'b000, `flags_word`=0, `save_depth`=0, `save_err`=0, all save slots 0.
- `take_branch` is 0 out of reset because `jmp_type` is decoded as none.
- ALU result at edge k appears on `flags` after edge k, giving one cycle of latency.
- A jump in the cycle immediately after a flag-producing instruction sees the new flags. There is no bypass of the current-cycle ALU flags.
- `take_branch` has zero latency (combinational); it is valid in the same cycle as `jmp_type`.
- `save_depth` updates on the same edge as the push or pop. RTI-restored flags are visible one cycle after `rti`.
- `rst` asserted mid-interrupt (depth > 0) empties the stack on the next edge.
- `stall` for M cycles freezes every register. Stimulus applied during stall is ignored except for `take_branch`.

## Configuration
- `CCR_NESTED_INT_EN` defined:
  - Two-slot save stack; `save_depth` ranges 0..2.
  - A third push sets `save_err`.
- Not defined:
  - One slot; `save_depth` ranges 0..1.
  - The second push sets `save_err`.
  - The bit-1 register is removed and `save_depth[1]` is tied to 0.

## Test plan
- Reset, then idle: `flags`=000, `take_branch`=0, `save_depth`=0. Then `alu_op`=6 with zero=1, carry=1, neg=0: the next cycle `flags`=3'b101.
- `flags`=101, then `alu_op`=7 with zero=0, neg=1: `flags`=3'b110, with C retained.
- `flags`.Z=1, `jmp_type`=1: `take_branch`=1 in the same cycle, and Z=0 the next cycle. Repeat with `flush`=1: `take_branch`=0 and Z stays 1.
- `flags`=011, `int_save`; then `alu_op`=11; then `rti`: `flags` reads 111, then 011, with `save_depth` going 1→0.
- Without `CCR_NESTED_INT_EN`: two pushes give `save_depth`=1, `save_err`=1 and the first entry intact. With the macro: the second push gives depth 2 and no error, and two pops restore in LIFO order.
- `stall`=1 for 3 cycles with `alu_op`=12 and C=1: C stays 1. Then `rst` with depth 1: the next cycle all outputs are 0.
